// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by on-chip RAM: independent single-burst read and write FSMs,
// INCR/FIXED/WRAP bursts, byte strobes. Define AXI_RAM_SLAVE_ERR_EN for DECERR outside the region.
module axi_ram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int MEM_BYTES  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  // write address
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // FSM state observation
  output logic [1:0]              dbg_wr_state,
  output logic                    dbg_rd_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // a source holds valid and its payload until that edge, and never waits on ready to raise valid.

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int BYTE_AW = $clog2(STRB_W);
  localparam int MEM_AW  = $clog2(MEM_BYTES);
  localparam int DEPTH   = MEM_BYTES / STRB_W;
  localparam int IDX_W   = MEM_AW - BYTE_AW;

`ifdef AXI_RAM_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  aw_err;
  logic [8:0]            w_cnt;

  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_err;
  logic [7:0]            r_cnt;

  logic [ADDR_WIDTH-1:0] w_next;
  logic [ADDR_WIDTH-1:0] r_next;
  logic                  aw_start_err;
  logic                  ar_start_err;
  logic                  w_beat_ok;
  logic                  mem_we;
  logic [IDX_W-1:0]      w_idx;
  logic                  rd_en;
  logic                  rd_err;
  logic [IDX_W-1:0]      rd_idx;
  logic                  unused_sideband;

  // WRAP keeps the low bits inside a (len+1)<<size block; reserved 2'b11 falls to FIXED.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] sum;
    incr      = ADDR_WIDTH'(1) << size;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    sum       = a + incr;
    case (burst)
      BURST_INCR: return sum;
      BURST_WRAP: return (a & ~wrap_mask) | (sum & wrap_mask);
      default:    return a;
    endcase
  endfunction

  assign aw_start_err = ERR_EN &&
    (s_axi_awaddr[ADDR_WIDTH-1:MEM_AW] != BASE_ADDR[ADDR_WIDTH-1:MEM_AW]);
  assign ar_start_err = ERR_EN &&
    (s_axi_araddr[ADDR_WIDTH-1:MEM_AW] != BASE_ADDR[ADDR_WIDTH-1:MEM_AW]);

  assign w_next    = next_addr(aw_addr, aw_len, aw_size, aw_burst);
  assign r_next    = next_addr(ar_addr, ar_len, ar_size, ar_burst);
  assign w_idx     = aw_addr[MEM_AW-1:BYTE_AW];
  assign w_beat_ok = (w_cnt <= {1'b0, aw_len});
  assign mem_we    = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready && w_beat_ok && !aw_err;

  assign dbg_wr_state = w_state;
  assign dbg_rd_state = r_state;

  assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

  // Write channel: beats past len+1 are swallowed until wlast closes the burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      aw_id         <= '0;
      aw_addr       <= '0;
      aw_len        <= '0;
      aw_size       <= '0;
      aw_burst      <= '0;
      aw_err        <= 1'b0;
      w_cnt         <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            aw_id         <= s_axi_awid;
            aw_addr       <= s_axi_awaddr;
            aw_len        <= s_axi_awlen;
            aw_size       <= s_axi_awsize;
            aw_burst      <= s_axi_awburst;
            aw_err        <= aw_start_err;
            w_cnt         <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid && s_axi_wready) begin
            aw_addr <= w_next;
            if (w_beat_ok) w_cnt <= w_cnt + 9'd1;
            if (s_axi_wlast) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= aw_err ? RESP_DECERR : RESP_OKAY;
              s_axi_bid    <= aw_id;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read port address: the AR address on accept, otherwise the prefetch of the following beat.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = s_axi_araddr[MEM_AW-1:BYTE_AW];
    rd_err = ar_start_err;
    if (r_state == R_IDLE) begin
      rd_en = s_axi_arvalid && s_axi_arready;
    end else begin
      rd_en  = s_axi_rvalid && s_axi_rready && !s_axi_rlast;
      rd_idx = r_next[MEM_AW-1:BYTE_AW];
      rd_err = ar_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_axi_rdata <= '0;
    end else if (rd_en) begin
      s_axi_rdata <= rd_err ? '0 : mem[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      ar_addr       <= '0;
      ar_len        <= '0;
      ar_size       <= '0;
      ar_burst      <= '0;
      ar_err        <= 1'b0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            ar_addr       <= s_axi_araddr;
            ar_len        <= s_axi_arlen;
            ar_size       <= s_axi_arsize;
            ar_burst      <= s_axi_arburst;
            ar_err        <= ar_start_err;
            r_cnt         <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rresp   <= ar_start_err ? RESP_DECERR : RESP_OKAY;
            s_axi_rid     <= s_axi_arid;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rlast <= ((r_cnt + 8'd1) == ar_len);
              ar_addr     <= r_next;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
